pkgstr_reader: RTL and testbench
================================

# pkgstr_reader

Reader end of the `testpkg::testpkg_str_t` record stream: accepts packed 33-bit records from a writer over a valid/ready handshake and buffers them in a small FIFO. It presents them unpacked (`signal_a`, `signal_b`) to a downstream consumer. It also keeps a running sum of `signal_b` for records popped with `signal_a` set, and reports buffer occupancy. It sits between the block that builds `pkgstr` records and any consumer of the individual fields.

## Interface
- `P_DEPTH`, 4 — FIFO depth in records; power of two, ≥2.
- `P_ACC_W`, 40 — accumulator width; ≥32.
- `CLK`  in  1  — clock, rising edge.
- `RST_X`  in  1  — asynchronous active-low reset.
- One clock; reset is asynchronous and active-low.
- `IN_VALID`  in  1  — writer offers a record.
- `IN_READY`  out  1  — reader can accept.
- `IN_DATA`  in  33  — packed `testpkg_str_t`: [32] = `signal_a`, [31:0] = `signal_b`.
- `OUT_VALID`  out  1  — head record available.
- `OUT_READY`  in  1  — consumer takes the head record.
- `OUT_SIGNAL_A`  out  1  — head record `signal_a`.
- `OUT_SIGNAL_B`  out  32  — head record `signal_b`.
- `COUNT`  out  $clog2(P_DEPTH+1)  — records currently stored.
- `ACC_CLR`  in  1  — synchronous clear of `ACC`.
- `ACC`  out  P_ACC_W  — sum of `signal_b` over popped records with `signal_a`=1.
- `OVF`  out  1  — sticky: `ACC` has wrapped since the last clear or reset.

## Operation
- Push: `IN_VALID && IN_READY` at a rising edge writes `IN_DATA` at the write pointer and advances the pointer.
- Pop: `OUT_VALID && OUT_READY` at a rising edge advances the read pointer.
- Pointers wrap modulo `P_DEPTH`.
- `IN_READY` = (`COUNT` < `P_DEPTH`). It does not look ahead to a same-cycle pop, so a full FIFO refuses a push even while it pops.
- `OUT_VALID` = (`COUNT` != 0). `OUT_SIGNAL_A`/`OUT_SIGNAL_B` are the storage entry at the read pointer; they are don't-care but stable while `OUT_VALID`=0.
- `COUNT`:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop (possible only when 0 < `COUNT` < `P_DEPTH`).
- Accumulator, evaluated at each edge:
  - If `ACC_CLR`: `ACC` ← (pop && `signal_a` ? zero-extended `signal_b` : 0); `OVF` ← 0.
  - Else if pop && `signal_a`: `ACC` ← (`ACC` + zero-extended `signal_b`) mod 2^`P_ACC_W`; `OVF` ← 1 when the add carries out.
  - Else `ACC` and `OVF` hold.
- Push and pop of the same record cannot occur in one cycle; an empty FIFO has `OUT_VALID`=0.
- Consumer protocol: the writer holds `IN_DATA` stable while `IN_VALID`=1 and `IN_READY`=0. The reader does not check this.

## Timing
- Reset (`RST_X`=0, asynchronous) values:
  - Pointers 0, `COUNT`=0.
  - `IN_READY`=1 once out of reset; 0 is not required during reset.
  - `OUT_VALID`=0, `ACC`=0, `OVF`=0.
  - `OUT_SIGNAL_A`=0, `OUT_SIGNAL_B`=0 (storage cleared).
- Reset mid-operation discards all buffered records. No handshake completes on the edge where `RST_X` is low.
- Latency: a record pushed at edge N is visible with `OUT_VALID`=1 after edge N, i.e. in cycle N+1. There is no combinational path from `IN_*` to `OUT_*`.
- `IN_READY`, `OUT_VALID` and `COUNT` are registered-state functions, with no combinational dependence on `IN_VALID` or `OUT_READY`.
- `ACC`/`OVF` update on the same edge as the pop that contributes.
- Full throughput: one push and one pop per cycle while partially full.

## Test plan
- Reset, then push {1, 0x0000_0010}, {0, 0x0000_0020}, {1, 0x0000_0005} back-to-back with `OUT_READY`=0 → `COUNT`=3, head = {1, 0x10}; then `OUT_READY`=1 for 3 cycles → records pop in order, `ACC`=0x15, `COUNT`=0, `OUT_VALID`=0.
- Push `P_DEPTH`=4 records with `OUT_READY`=0 → `IN_READY`=0 after the 4th. A 5th record held on `IN_VALID` is not accepted while `OUT_READY`=1 pops in the same cycle. It is accepted the next cycle, and order is preserved.
- Continuous `IN_VALID`=1 and `OUT_READY`=1 for 20 cycles with an incrementing `signal_b` and `signal_a`=1 → one record per cycle after the first, `COUNT` steady at 1, pointers wrap correctly, and `ACC` equals the sum of the popped values.
- With `P_ACC_W`=40, preload `ACC` to 0xFF_FFFF_FFF0 via pops, then pop {1, 0x20} → `ACC`=0x10, `OVF`=1. Then `ACC_CLR` together with a pop of {1, 0x7} → `ACC`=0x7, `OVF`=0.
- Pop of {0, 0xFFFF_FFFF} → `ACC` unchanged.
- Deassert `RST_X` asynchronously mid-edge with 3 records buffered → `COUNT`=0, `OUT_VALID`=0, `ACC`=0 immediately, with no clock edge required. After release, the first push appears as the head.

Source files
------------

// File: rtl/pkgstr_reader.sv
// Reader end of the pkgstr record stream: buffers packed {signal_a, signal_b}
// records in a FIFO, presents the head unpacked, and sums signal_b for popped
// records that have signal_a set.
//
// Ports:
//   CLK, RST_X           clock (rising edge), async active-low reset
//   IN_VALID/IN_READY    writer handshake, IN_DATA = {signal_a, signal_b}
//   OUT_VALID/OUT_READY  consumer handshake, OUT_SIGNAL_A/B = head record
//   COUNT                records currently stored
//   ACC_CLR              synchronous clear of ACC/OVF
//   ACC, OVF             running sum and sticky wrap flag
module pkgstr_reader #(
    parameter int P_DEPTH = 4,
    parameter int P_ACC_W = 40
) (
    input  logic                           CLK,
    input  logic                           RST_X,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic [32:0]                    IN_DATA,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic                           OUT_SIGNAL_A,
    output logic [31:0]                    OUT_SIGNAL_B,
    output logic [$clog2(P_DEPTH+1)-1:0]   COUNT,
    input  logic                           ACC_CLR,
    output logic [P_ACC_W-1:0]             ACC,
    output logic                           OVF
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = $clog2(P_DEPTH + 1);

    logic [32:0]        r_mem [P_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [P_ACC_W-1:0] r_acc;
    logic               r_ovf;

    logic               w_push;
    logic               w_pop;
    logic [32:0]        w_head;
    logic [P_ACC_W-1:0] w_b_ext;
    logic [P_ACC_W:0]   w_sum;
    logic               w_add;

    // Ready/valid come from stored count only; a full FIFO
    // refuses a push even when it pops in the same cycle.
    assign IN_READY  = (r_count < CW'(P_DEPTH));
    assign OUT_VALID = (r_count != '0);

    assign w_push = IN_VALID && IN_READY;
    assign w_pop  = OUT_VALID && OUT_READY;
    assign w_head = r_mem[r_rptr];

    assign OUT_SIGNAL_A = w_head[32];
    assign OUT_SIGNAL_B = w_head[31:0];
    assign COUNT        = r_count;
    assign ACC          = r_acc;
    assign OVF          = r_ovf;

    assign w_add   = w_pop && w_head[32];
    assign w_b_ext = {{(P_ACC_W-32){1'b0}}, w_head[31:0]};
    // Extra top bit captures the carry out of the accumulator.
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_b_ext};

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= IN_DATA;
            r_wptr        <= r_wptr + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A clear still takes the contribution of a same-cycle pop.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (ACC_CLR) begin
            r_acc <= w_add ? w_b_ext : '0;
            r_ovf <= 1'b0;
        end else if (w_add) begin
            r_acc <= w_sum[P_ACC_W-1:0];
            if (w_sum[P_ACC_W]) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkgstr_reader.sv
// Self-checking bench for pkgstr_reader: table-driven vectors plus
// hand-written streaming, overflow and async-reset sequences.
module tb_pkgstr_reader;

    logic        CLK;
    logic        RST_X;
    logic        IN_VALID;
    logic        IN_READY;
    logic [32:0] IN_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_SIGNAL_A;
    logic [31:0] OUT_SIGNAL_B;
    logic [2:0]  COUNT;
    logic        ACC_CLR;
    logic [39:0] ACC;
    logic        OVF;

    int n_vec = 0;
    int n_bad = 0;

    pkgstr_reader #(.P_DEPTH(4), .P_ACC_W(40)) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_DATA      (IN_DATA),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_SIGNAL_A (OUT_SIGNAL_A),
        .OUT_SIGNAL_B (OUT_SIGNAL_B),
        .COUNT        (COUNT),
        .ACC_CLR      (ACC_CLR),
        .ACC          (ACC),
        .OVF          (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iv;
        logic [32:0] d;
        logic        ordy;
        logic        clr;
        logic [2:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic        chk_head;
        logic [32:0] e_head;
        logic [39:0] e_acc;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [32:0] d, logic ordy,
                                logic clr, logic [2:0] cnt, logic ov,
                                logic ir, logic ch, logic [32:0] hd,
                                logic [39:0] acc, logic ovf);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
        v.e_cnt = cnt; v.e_ov = ov; v.e_ir = ir;
        v.chk_head = ch; v.e_head = hd; v.e_acc = acc; v.e_ovf = ovf;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic [32:0] d, logic ordy, logic clr);
        IN_VALID  = iv;
        IN_DATA   = d;
        OUT_READY = ordy;
        ACC_CLR   = clr;
        @(posedge CLK);
        #1;
    endtask

    logic [39:0] m_acc;
    logic [39:0] m_exp;
    logic [32:0] hd;

    initial begin
        RST_X     = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        OUT_READY = 1'b0;
        ACC_CLR   = 1'b0;

        // order check and full/refuse sequence
        tbl.push_back(mk(1, {1'b1,32'h10}, 0, 0, 1, 1, 1, 1, {1'b1,32'h10}, 40'h0, 0));
        tbl.push_back(mk(1, {1'b0,32'h20}, 0, 0, 2, 1, 1, 1, {1'b1,32'h10}, 40'h0, 0));
        tbl.push_back(mk(1, {1'b1,32'h05}, 0, 0, 3, 1, 1, 1, {1'b1,32'h10}, 40'h0, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 2, 1, 1, 1, {1'b0,32'h20}, 40'h10, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 1, 1, 1, 1, {1'b1,32'h05}, 40'h10, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 0, 0, 1, 0, 33'h0,         40'h15, 0));
        tbl.push_back(mk(1, {1'b0,32'hA1}, 0, 0, 1, 1, 1, 1, {1'b0,32'hA1}, 40'h15, 0));
        tbl.push_back(mk(1, {1'b1,32'hA2}, 0, 0, 2, 1, 1, 1, {1'b0,32'hA1}, 40'h15, 0));
        tbl.push_back(mk(1, {1'b0,32'hA3}, 0, 0, 3, 1, 1, 1, {1'b0,32'hA1}, 40'h15, 0));
        tbl.push_back(mk(1, {1'b1,32'hA4}, 0, 0, 4, 1, 0, 1, {1'b0,32'hA1}, 40'h15, 0));
        tbl.push_back(mk(1, {1'b1,32'hA5}, 1, 0, 3, 1, 1, 1, {1'b1,32'hA2}, 40'h15, 0));
        tbl.push_back(mk(1, {1'b1,32'hA5}, 0, 0, 4, 1, 0, 1, {1'b1,32'hA2}, 40'h15, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 3, 1, 1, 1, {1'b0,32'hA3}, 40'hB7, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 2, 1, 1, 1, {1'b1,32'hA4}, 40'hB7, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 1, 1, 1, 1, {1'b1,32'hA5}, 40'h15B, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 0, 0, 1, 0, 33'h0,         40'h200, 0));
        // signal_a=0 record must not touch the sum
        tbl.push_back(mk(1, {1'b0,32'hFFFF_FFFF}, 0, 0, 1, 1, 1, 1, {1'b0,32'hFFFF_FFFF}, 40'h200, 0));
        tbl.push_back(mk(0, 33'h0,         1, 0, 0, 0, 1, 0, 33'h0,         40'h200, 0));
        // clear with no pop
        tbl.push_back(mk(0, 33'h0,         0, 1, 0, 0, 1, 0, 33'h0,         40'h0, 0));

        #12;
        RST_X = 1'b1;
        @(posedge CLK);
        #1;

        chk("rst_state", {COUNT, OUT_VALID, IN_READY, ACC, OVF},
            {3'd0, 1'b0, 1'b1, 40'h0, 1'b0});
        chk("rst_head", {OUT_SIGNAL_A, OUT_SIGNAL_B}, 33'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr);
            chk($sformatf("vec%0d", i),
                {COUNT, OUT_VALID, IN_READY, ACC, OVF},
                {tbl[i].e_cnt, tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_acc, tbl[i].e_ovf});
            if (tbl[i].chk_head) begin
                chk($sformatf("vec%0d_head", i),
                    {OUT_SIGNAL_A, OUT_SIGNAL_B}, tbl[i].e_head);
            end
        end

        // streaming: one in, one out per cycle
        m_acc = 40'h0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {1'b1, 32'h100 + 32'(i)}, 1'b1, 1'b0);
            if (i > 0) m_acc = m_acc + 40'(32'h100 + 32'(i - 1));
            chk($sformatf("strm%0d_cnt", i), COUNT, 3'd1);
            chk($sformatf("strm%0d_head", i),
                {OUT_SIGNAL_A, OUT_SIGNAL_B}, {1'b1, 32'h100 + 32'(i)});
            chk($sformatf("strm%0d_acc", i), ACC, m_acc);
        end
        drive(1'b0, 33'h0, 1'b1, 1'b0);
        m_acc = m_acc + 40'h113;
        chk("strm_drain", {COUNT, OUT_VALID, ACC}, {3'd0, 1'b0, m_acc});

        // preload ACC to 0xFF_FFFF_FFF0, then wrap it
        drive(1'b0, 33'h0, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, {1'b1, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        end
        drive(1'b1, {1'b1, 32'hF0}, 1'b1, 1'b0);
        drive(1'b0, 33'h0, 1'b1, 1'b0);
        m_exp = 40'hFF_FFFF_FFF0;
        chk("preload", {ACC, OVF, COUNT}, {m_exp, 1'b0, 3'd0});
        drive(1'b1, {1'b1, 32'h20}, 1'b0, 1'b0);
        drive(1'b0, 33'h0, 1'b1, 1'b0);
        chk("wrap", {ACC, OVF}, {40'h10, 1'b1});
        drive(1'b1, {1'b1, 32'h7}, 1'b0, 1'b0);
        drive(1'b0, 33'h0, 1'b1, 1'b1);
        chk("clr_pop", {ACC, OVF}, {40'h7, 1'b0});

        // async reset with three records buffered
        drive(1'b1, {1'b0, 32'h31}, 1'b0, 1'b0);
        drive(1'b1, {1'b0, 32'h32}, 1'b0, 1'b0);
        drive(1'b1, {1'b0, 32'h34}, 1'b0, 1'b0);
        IN_VALID = 1'b0;
        chk("pre_rst", {COUNT, ACC}, {3'd3, 40'h7});
        #2;
        RST_X = 1'b0;
        #1;
        chk("async_rst", {COUNT, OUT_VALID, ACC, OVF},
            {3'd0, 1'b0, 40'h0, 1'b0});
        hd = {OUT_SIGNAL_A, OUT_SIGNAL_B};
        chk("async_rst_head", hd, 33'h0);
        @(posedge CLK);
        #3;
        RST_X = 1'b1;
        @(posedge CLK);
        #1;
        drive(1'b1, {1'b1, 32'h33}, 1'b0, 1'b0);
        chk("post_rst", {COUNT, OUT_VALID, IN_READY}, {3'd1, 1'b1, 1'b1});
        chk("post_rst_head", {OUT_SIGNAL_A, OUT_SIGNAL_B}, {1'b1, 32'h33});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
